// File: rtl/music_box_state_controller_if.sv
// Push buttons, per-mode completion flags and mode status shared by the music box mode sequencer.
// The sequencer uses the slave view; the environment driving the buttons uses the master view.
interface music_box_state_controller_if;
  logic [3:0]  button_n;
  logic [4:0]  stateComplete;
  logic [4:0]  currentState;
  logic        stateEntered;
  logic        recordingValid;
  logic [31:0] debugString;

  modport master (
    output button_n,
    output stateComplete,
    input  currentState,
    input  stateEntered,
    input  recordingValid,
    input  debugString
  );

  modport slave (
    input  button_n,
    input  stateComplete,
    output currentState,
    output stateEntered,
    output recordingValid,
    output debugString
  );
endinterface

// File: rtl/music_box_state_controller.sv
// Music box mode sequencer: debounces the request buttons and drives the shared currentState bus.
// It returns to idle on a completion flag and tracks whether a valid recording exists.
module music_box_state_controller #(
  parameter int unsigned DEBOUNCE_CYCLES       = 500000,
  parameter int unsigned COMPLETE_GUARD_CYCLES = 100000,
  parameter int unsigned NUM_BUTTONS           = 4
) (
  input logic                         clock_50Mhz,
  input logic                         reset_n,
  music_box_state_controller_if.slave bus
);

  localparam int unsigned     CntW         = 20;
  localparam logic [CntW-1:0] DebounceLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] GuardLoad    = CntW'(COMPLETE_GUARD_CYCLES);

  typedef enum logic [2:0] {
    StDoNothing     = 3'd0,
    StPlaySong1     = 3'd1,
    StPlaySong2     = 3'd2,
    StPlayRecording = 3'd3,
    StMakeRecording = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Button input path: synchronizer, debouncer, press-edge detector
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] sync1_q;
  logic [NUM_BUTTONS-1:0] sync2_q;
  logic [NUM_BUTTONS-1:0] level_q;
  logic [NUM_BUTTONS-1:0] level_d;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [NUM_BUTTONS-1:0] press_d;
  logic [CntW-1:0]        db_cnt_q [NUM_BUTTONS];
  logic [CntW-1:0]        db_cnt_d [NUM_BUTTONS];

  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DebounceLast) begin
          level_d[i] = sync2_q[i];
          // Only an accepted high-to-low transition is a press; releases are silent.
          press_d[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      press_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= bus.button_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode sequencer
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  state_e                 state_d;
  logic                   rec_valid_q;
  logic                   rec_valid_d;
  logic                   entered_q;
  logic                   entered_d;
  logic [CntW-1:0]        guard_q;
  logic [CntW-1:0]        guard_d;
  logic [NUM_BUTTONS-1:0] winner;
  logic                   any_press;
  logic                   complete_ok;

  // Isolate the lowest set press bit so simultaneous presses resolve to the lowest index.
  assign winner    = press_q & (~press_q + NUM_BUTTONS'(1));
  assign any_press = |press_q;
  // A stale flag from the previous pass of a slow block is ignored until the guard drains.
  assign complete_ok = bus.stateComplete[state_q] && (guard_q == '0);

  always_comb begin
    state_d     = state_q;
    rec_valid_d = rec_valid_q;
    guard_d     = (guard_q == '0) ? '0 : guard_q - CntW'(1);

    if (state_q == StDoNothing) begin
      unique case (winner)
        4'b0001: state_d = StPlaySong1;
        4'b0010: state_d = StPlaySong2;
        4'b0100: if (rec_valid_q) state_d = StPlayRecording;
        4'b1000: state_d = StMakeRecording;
        default: ;
      endcase
    end else begin
      if (complete_ok && (state_q == StMakeRecording)) begin
        rec_valid_d = 1'b1;
      end
      if (complete_ok || any_press) begin
        state_d = StDoNothing;
      end
    end

    entered_d = (state_q == StDoNothing) && (state_d != StDoNothing);
    if (entered_d) begin
      guard_d = GuardLoad;
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      state_q     <= StDoNothing;
      rec_valid_q <= 1'b0;
      entered_q   <= 1'b0;
      guard_q     <= '0;
    end else begin
      state_q     <= state_d;
      rec_valid_q <= rec_valid_d;
      entered_q   <= entered_d;
      guard_q     <= guard_d;
    end
  end

  assign bus.currentState   = {2'b00, state_q};
  assign bus.stateEntered   = entered_q;
  assign bus.recordingValid = rec_valid_q;
  assign bus.debugString    = {2'b00, state_q, rec_valid_q, 2'b00, press_q, guard_q};

endmodule

// File: tb/tb_music_box_state_controller.sv
// Bench for the music box mode sequencer: directed scenarios followed by random button and
// completion traffic, all checked every cycle against a window-based behavioural model.
module tb_music_box_state_controller;

  localparam int unsigned D = 4;
  localparam int unsigned G = 8;

  logic clock_50Mhz = 1'b0;
  logic reset_n     = 1'b0;

  music_box_state_controller_if bus ();

  music_box_state_controller #(
    .DEBOUNCE_CYCLES      (D),
    .COMPLETE_GUARD_CYCLES(G),
    .NUM_BUTTONS          (4)
  ) dut (
    .clock_50Mhz(clock_50Mhz),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 clock_50Mhz = ~clock_50Mhz;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode as an integer, entry time stamp for the guard, raw sample history.
  int       cyc           = 0;
  int       m_mode        = 0;
  bit       m_rv          = 1'b0;
  bit       m_entered     = 1'b0;
  bit [3:0] m_press       = '0;
  bit [3:0] m_acc         = '1;
  int       m_entry       = 0;
  bit       m_entry_valid = 1'b0;
  bit       hist [4][$];

  int hold [4];
  int sc_hold;

  function automatic int model_guard();
    int d;
    if (!m_entry_valid) return 0;
    d = cyc - m_entry;
    return (d >= int'(G)) ? 0 : int'(G) - d;
  endfunction

  function automatic void model_edge();
    int  k;
    int  nxt;
    bit  done;
    bit  all_diff;
    int  n;
    cyc++;
    if (!reset_n) begin
      m_mode        = 0;
      m_rv          = 1'b0;
      m_entered     = 1'b0;
      m_press       = '0;
      m_acc         = '1;
      m_entry_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
        hist[b].delete();
        repeat (D + 2) hist[b].push_back(1'b1);
      end
      return;
    end
    nxt = m_mode;
    k   = -1;
    for (int b = 3; b >= 0; b--) if (m_press[b]) k = b;
    if (m_mode == 0) begin
      if (k >= 0 && !(k == 2 && !m_rv)) nxt = k + 1;
    end else begin
      done = bus.stateComplete[m_mode] && m_entry_valid && ((cyc - m_entry) > int'(G));
      if (done && m_mode == 4) m_rv = 1'b1;
      if (done || k >= 0) nxt = 0;
    end
    m_entered = (m_mode == 0) && (nxt != 0);
    if (m_entered) begin
      m_entry       = cyc;
      m_entry_valid = 1'b1;
    end
    m_mode = nxt;
    // A level is accepted once the raw value seen two samples late differs for D samples in a row.
    for (int b = 0; b < 4; b++) begin
      hist[b].push_back(bus.button_n[b]);
      if (hist[b].size() > 32) void'(hist[b].pop_front());
      n        = hist[b].size();
      all_diff = 1'b1;
      for (int j = 0; j < int'(D); j++) begin
        if (hist[b][n - 3 - j] == m_acc[b]) all_diff = 1'b0;
      end
      m_press[b] = 1'b0;
      if (all_diff) begin
        m_acc[b]   = ~m_acc[b];
        m_press[b] = (m_acc[b] == 1'b0);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [31:0] dbg;
    @(posedge clock_50Mhz);
    model_edge();
    #1;
    dbg = {5'(m_mode), m_rv, 2'b00, m_press, 20'(model_guard())};
    check("currentState", 32'(bus.currentState), 32'(m_mode));
    check("stateEntered", 32'(bus.stateEntered), 32'(m_entered));
    check("recordingValid", 32'(bus.recordingValid), 32'(m_rv));
    check("debugString", bus.debugString, dbg);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(1);
  endtask

  task automatic press(input logic [3:0] mask_n, input int len);
    bus.button_n = mask_n;
    run(len);
    bus.button_n = '1;
  endtask

  initial begin
    bus.button_n      = '1;
    bus.stateComplete = '0;

    // Long press on button 3 enters MakeRecording 2 + D samples after the first low sample.
    do_reset();
    check("s1_reset_state", 32'(bus.currentState), 32'd0);
    bus.button_n = 4'b0111;
    run(6);
    check("s1_idle_before", 32'(bus.currentState), 32'd0);
    run(1);
    check("s1_enter", 32'(bus.currentState), 32'd4);
    check("s1_pulse", 32'(bus.stateEntered), 32'd1);
    run(1);
    check("s1_pulse_end", 32'(bus.stateEntered), 32'd0);
    run(2);
    bus.button_n = '1;
    run(8);
    check("s1_hold", 32'(bus.currentState), 32'd4);
    check("s1_rv", 32'(bus.recordingValid), 32'd0);

    // Completion held from 3 cycles after entry is honoured only once the guard drains.
    do_reset();
    bus.button_n = 4'b0111;
    run(7);
    check("s2_enter", 32'(bus.currentState), 32'd4);
    run(3);
    bus.button_n      = '1;
    bus.stateComplete = 5'b10000;
    run(5);
    check("s2_guarded", 32'(bus.currentState), 32'd4);
    check("s2_guard_zero", 32'(bus.debugString[19:0]), 32'd0);
    run(1);
    check("s2_exit", 32'(bus.currentState), 32'd0);
    check("s2_rv", 32'(bus.recordingValid), 32'd1);
    bus.stateComplete = '0;
    run(4);

    // PlayRecording is refused until a recording has completed.
    do_reset();
    press(4'b1011, 8);
    run(8);
    check("s3_rv_gate", 32'(bus.currentState), 32'd0);
    press(4'b0111, 8);
    bus.stateComplete = 5'b10000;
    run(12);
    bus.stateComplete = '0;
    run(2);
    check("s3_rec_done", 32'(bus.currentState), 32'd0);
    check("s3_rec_rv", 32'(bus.recordingValid), 32'd1);
    press(4'b1011, 8);
    check("s3_play", 32'(bus.currentState), 32'd3);
    run(4);

    // Buttons 1 and 3 debounce on the same cycle: the lower index wins.
    do_reset();
    press(4'b0101, 8);
    check("s4_lowest", 32'(bus.currentState), 32'd2);
    run(8);

    // Abort from MakeRecording leaves recordingValid clear.
    do_reset();
    press(4'b0111, 8);
    run(4);
    check("s5_in_rec", 32'(bus.currentState), 32'd4);
    press(4'b1110, 8);
    check("s5_abort", 32'(bus.currentState), 32'd0);
    check("s5_rv", 32'(bus.recordingValid), 32'd0);
    run(8);

    // A 3-cycle glitch is rejected; reset in an active state restores reset values.
    do_reset();
    press(4'b1110, 3);
    run(8);
    check("s6_glitch", 32'(bus.currentState), 32'd0);
    press(4'b1110, 8);
    check("s6_play1", 32'(bus.currentState), 32'd1);
    run(2);
    reset_n = 1'b0;
    run(1);
    check("s6_rst_state", 32'(bus.currentState), 32'd0);
    check("s6_rst_entered", 32'(bus.stateEntered), 32'd0);
    check("s6_rst_rv", 32'(bus.recordingValid), 32'd0);
    check("s6_rst_debug", bus.debugString, 32'd0);
    reset_n = 1'b1;
    run(2);

    // Random traffic with occasional mid-run resets.
    for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 60);
    sc_hold = 0;
    repeat (3000) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          bus.button_n[b] = ~bus.button_n[b];
          hold[b]         = $urandom_range(1, 60);
        end else begin
          hold[b]--;
        end
      end
      if (sc_hold == 0) begin
        bus.stateComplete = 5'($urandom);
        sc_hold           = $urandom_range(1, 20);
      end else begin
        sc_hold--;
      end
      reset_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
